operand_b_decode_stage: RTL



---
 rtl/operand_pkg.sv | 51 +++++
 rtl/opb_field_decode.sv | 24 ++
 rtl/operand_b_decode_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/operand_pkg.sv
// Shared types and constants for the ALU operand-B decode stage.
// The illegal field of opb_bundle_t exists only when OPB_ILLEGAL_DETECT_EN is defined.
package operand_pkg;

   localparam int OPB_XLEN = 32;

   localparam logic [2:0] SI_REG   = 3'b000;
   localparam logic [2:0] SI_IMM_I = 3'b001;
   localparam logic [2:0] SI_IMM_S = 3'b010;
   localparam logic [2:0] SI_IMM_U = 3'b011;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      logic [2:0]          si;
      logic [OPB_XLEN-1:0] imm12_I;
      logic [OPB_XLEN-1:0] imm12_S;
      logic [19:0]         imm20;
      logic [OPB_XLEN-1:0] pc;
`ifdef OPB_ILLEGAL_DETECT_EN
      logic                illegal;
`endif
   } opb_bundle_t;

   function automatic logic [2:0] opcode_to_si(input logic [6:0] opcode);
      case (opcode)
         OPC_OPIMM, OPC_LOAD, OPC_JALR: opcode_to_si = SI_IMM_I;
         OPC_STORE:                     opcode_to_si = SI_IMM_S;
         OPC_LUI, OPC_AUIPC:            opcode_to_si = SI_IMM_U;
         default:                       opcode_to_si = SI_REG;
      endcase
   endfunction

   function automatic logic opcode_known(input logic [6:0] opcode);
      case (opcode)
         OPC_OP, OPC_BRANCH, OPC_JAL,
         OPC_OPIMM, OPC_LOAD, OPC_JALR,
         OPC_STORE, OPC_LUI, OPC_AUIPC: opcode_known = 1'b1;
         default:                       opcode_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/opb_field_decode.sv
// Combinational instruction -> operand-B bundle decoder.
// Immediate fields are extracted for every opcode; the consumer picks by si.
module opb_field_decode
   import operand_pkg::*;
(
   input  logic [31:0]         instr,
   input  logic [OPB_XLEN-1:0] pc,
   output opb_bundle_t         bundle
);

   always_comb begin
      // NOTE: default the whole output first so no path leaves a field unassigned (no latch).
      bundle         = '0;
      bundle.si      = opcode_to_si(instr[6:0]);
      bundle.imm12_I = {{(OPB_XLEN-12){1'b0}}, instr[31:20]};
      bundle.imm12_S = {{(OPB_XLEN-12){1'b0}}, instr[31:25], instr[11:7]};
      bundle.imm20   = instr[31:12];
      bundle.pc      = pc;
`ifdef OPB_ILLEGAL_DETECT_EN
      bundle.illegal = !opcode_known(instr[6:0]) || (instr[1:0] != 2'b11);
`endif
   end

endmodule

// File: rtl/operand_b_decode_stage.sv
// Operand-B decode stage: registered decoded bundle with a 2-entry skid buffer.
// Define OPB_ILLEGAL_DETECT_EN to add the registered 'illegal' output.
module operand_b_decode_stage
   import operand_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      Si,
   output logic [XLEN-1:0] imm12_I,
   output logic [XLEN-1:0] imm12_S,
   output logic [19:0]     imm20,
   output logic [XLEN-1:0] pc_out
`ifdef OPB_ILLEGAL_DETECT_EN
  ,output logic            illegal
`endif
);

   opb_bundle_t dec;
   opb_bundle_t main_q;
   opb_bundle_t skid_q;
   logic        main_v, skid_v;
   logic        main_v_next, skid_v_next;
   logic        load_main, load_skid, main_from_skid;
   logic        accept;

   opb_field_decode u_decode (
      .instr  (instr),
      .pc     (pc_in),
      .bundle (dec)
   );

   // in_ready is a pure function of a flop, so out_ready never reaches it combinationally.
   assign in_ready = !skid_v;
   assign accept   = in_valid && in_ready && !reset;

   always_comb begin
      main_v_next    = main_v;
      skid_v_next    = skid_v;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         main_v_next = 1'b0;
         skid_v_next = 1'b0;
      end else if (!main_v || out_ready) begin
         // A held skid entry is older than anything arriving now, so it moves first.
         if (skid_v) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            main_v_next    = 1'b1;
            skid_v_next    = 1'b0;
         end else if (accept) begin
            load_main   = 1'b1;
            main_v_next = 1'b1;
         end else begin
            main_v_next = 1'b0;
         end
      end else if (accept) begin
         load_skid   = 1'b1;
         skid_v_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         main_v    <= 1'b0;
         skid_v    <= 1'b0;
         main_q    <= '0;
         main_q.pc <= RESET_PC;
      end else begin
         main_v <= main_v_next;
         skid_v <= skid_v_next;
         if (load_main) main_q <= main_from_skid ? skid_q : dec;
      end
   end

   // NOTE: skid data has no reset; skid_v alone says whether it holds anything.
   always_ff @(posedge clk) begin
      if (load_skid) skid_q <= dec;
   end

   assign out_valid = main_v;
   assign Si        = main_q.si;
   assign imm12_I   = main_q.imm12_I;
   assign imm12_S   = main_q.imm12_S;
   assign imm20     = main_q.imm20;
   assign pc_out    = main_q.pc;
`ifdef OPB_ILLEGAL_DETECT_EN
   assign illegal   = main_q.illegal;
`endif

endmodule
